// File: rtl/ndn_pkg.sv
// rtl/ndn_pkg.sv - shared NDN widths, PIT entry record and gate FSM states
package ndn_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int BYTE_W   = 8;
  localparam int FACES_W  = 4;

  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
    logic [FACES_W-1:0]  faces;
  } pit_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_GRANT,
    ST_XFER,
    ST_CLEAR
  } gate_state_t;

endpackage

// File: rtl/pit_entry_table.sv
// rtl/pit_entry_table.sv - PIT storage with aggregation match, lowest-free-slot insert, scan read port
// Optional per-entry expiry when PIT_TIMEOUT_EN is defined.
module pit_entry_table
  import ndn_pkg::*;
#(
  parameter int PIT_ENTRIES = 8,
  parameter int IDX_W       = $clog2(PIT_ENTRIES)
`ifdef PIT_TIMEOUT_EN
  ,
  parameter int LIFETIME    = 4096
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_en,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  input  logic [FACES_W-1:0]  ins_face,
  output logic                ins_drop,
  input  logic                clr_en,
  input  logic [IDX_W-1:0]    clr_idx,
`ifdef PIT_TIMEOUT_EN
  input  logic                hold_en,
  input  logic [IDX_W-1:0]    hold_idx,
`endif
  input  logic [IDX_W-1:0]    rd_idx,
  output pit_entry_t          rd_entry
);

  pit_entry_t             ent_q [PIT_ENTRIES];
  logic [PIT_ENTRIES-1:0] match;
  logic                   hit_any;
  logic                   free_any;
  logic [IDX_W-1:0]       free_idx;

`ifdef PIT_TIMEOUT_EN
  localparam int AGE_W = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  logic [AGE_W-1:0] age_q [PIT_ENTRIES];
`endif

  always_comb begin
    match = '0;
    for (int i = 0; i < PIT_ENTRIES; i++) begin
      match[i] = ent_q[i].valid && (ent_q[i].len == ins_len) && (ent_q[i].prefix == ins_prefix);
    end
  end

  assign hit_any = |match;

  // Scanning downward leaves the lowest free index as the final assignment.
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = PIT_ENTRIES - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  assign ins_drop = ins_en && !hit_any && !free_any;
  assign rd_entry = ent_q[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIT_ENTRIES; i++) begin
        ent_q[i] <= '0;
`ifdef PIT_TIMEOUT_EN
        age_q[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < PIT_ENTRIES; i++) begin
        if (clr_en && (clr_idx == IDX_W'(i))) begin
          ent_q[i].valid <= 1'b0;
        end else if (ins_en && match[i]) begin
          ent_q[i].faces <= ent_q[i].faces | ins_face;
`ifdef PIT_TIMEOUT_EN
          age_q[i] <= '0;
`endif
        end else if (ins_en && !hit_any && free_any && (free_idx == IDX_W'(i))) begin
          ent_q[i] <= '{valid: 1'b1, prefix: ins_prefix, len: ins_len, faces: ins_face};
`ifdef PIT_TIMEOUT_EN
          age_q[i] <= '0;
        end else if (ent_q[i].valid && !(hold_en && (hold_idx == IDX_W'(i)))) begin
          if (age_q[i] == AGE_W'(LIFETIME - 1)) begin
            ent_q[i].valid <= 1'b0;
          end else begin
            age_q[i] <= age_q[i] + AGE_W'(1);
          end
`endif
        end
      end
    end
  end

endmodule

// File: rtl/pit_data_gate.sv
// rtl/pit_data_gate.sv - PIT gate: interest insert, FIB match scan, grant and payload streaming
// PIT_TIMEOUT_EN enables entry expiry after LIFETIME cycles.
module pit_data_gate
  import ndn_pkg::*;
#(
  parameter int PIT_ENTRIES = 8,
  parameter int FACES       = 4,
  parameter int DATA_BYTES  = 1024
`ifdef PIT_TIMEOUT_EN
  ,
  parameter int LIFETIME    = 4096
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interest_valid,
  input  logic [PREFIX_W-1:0] interest_prefix,
  input  logic [LEN_W-1:0]    interest_len,
  input  logic [FACES-1:0]    interest_face,
  output logic                interest_ready,
  output logic                interest_drop,
  input  logic                fib_prefix_ready,
  input  logic [PREFIX_W-1:0] fib_prefix,
  input  logic [LEN_W-1:0]    fib_len,
  output logic                fib_rejected,
  output logic                fib_start_send,
  input  logic [BYTE_W-1:0]   fib_data,
  output logic                face_valid,
  output logic [BYTE_W-1:0]   face_data,
  output logic [FACES-1:0]    face_mask,
  output logic                face_last,
  output logic                busy
);

  localparam int IDX_W = $clog2(PIT_ENTRIES);
  localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  gate_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PREFIX_W-1:0] req_prefix_q;
  logic [LEN_W-1:0]    req_len_q;
  logic                reject_d;
  logic                clr_en;
  logic                ins_en;
  logic                ins_drop;
  logic                hit;
  logic                last_byte;
  pit_entry_t          rd_entry;

  logic                fib_rejected_q, interest_drop_q;
  logic                face_valid_q, face_last_q;
  logic [BYTE_W-1:0]   face_data_q;
  logic [FACES-1:0]    face_mask_q;

  // A simultaneous FIB request takes the cycle; the interest is held off.
  assign interest_ready = (state_q == ST_IDLE) && !fib_prefix_ready && !rst;
  assign ins_en         = interest_valid && interest_ready;

  pit_entry_table #(
    .PIT_ENTRIES (PIT_ENTRIES),
    .IDX_W       (IDX_W)
`ifdef PIT_TIMEOUT_EN
    ,
    .LIFETIME    (LIFETIME)
`endif
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .ins_en     (ins_en),
    .ins_prefix (interest_prefix),
    .ins_len    (interest_len),
    .ins_face   (interest_face),
    .ins_drop   (ins_drop),
    .clr_en     (clr_en),
    .clr_idx    (idx_q),
`ifdef PIT_TIMEOUT_EN
    .hold_en    ((state_q == ST_GRANT) || (state_q == ST_XFER) || (state_q == ST_CLEAR)),
    .hold_idx   (idx_q),
`endif
    .rd_idx     (idx_q),
    .rd_entry   (rd_entry)
  );

  assign hit       = rd_entry.valid && (rd_entry.len == req_len_q) && (rd_entry.prefix == req_prefix_q);
  assign last_byte = (cnt_q == CNT_W'(DATA_BYTES - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    clr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fib_prefix_ready) begin
          state_d = ST_LOOKUP;
          idx_d   = '0;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          state_d = ST_GRANT;
        end else if (idx_q == IDX_W'(PIT_ENTRIES - 1)) begin
          state_d  = ST_IDLE;
          reject_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_GRANT: begin
        state_d = ST_XFER;
        cnt_d   = '0;
      end
      ST_XFER: begin
        if (last_byte) begin
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLEAR: begin
        clr_en  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bytes taken during XFER appear on the faces one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_prefix_q    <= '0;
      req_len_q       <= '0;
      fib_rejected_q  <= 1'b0;
      interest_drop_q <= 1'b0;
      face_valid_q    <= 1'b0;
      face_last_q     <= 1'b0;
      face_data_q     <= '0;
      face_mask_q     <= '0;
    end else begin
      if ((state_q == ST_IDLE) && fib_prefix_ready) begin
        req_prefix_q <= fib_prefix;
        req_len_q    <= fib_len;
      end
      fib_rejected_q  <= reject_d;
      interest_drop_q <= ins_drop;
      face_valid_q    <= (state_q == ST_XFER);
      face_last_q     <= (state_q == ST_XFER) && last_byte;
      face_data_q     <= (state_q == ST_XFER) ? fib_data : '0;
      face_mask_q     <= (state_q == ST_XFER) ? rd_entry.faces : '0;
    end
  end

  assign fib_rejected   = fib_rejected_q;
  assign fib_start_send = (state_q == ST_GRANT);
  assign interest_drop  = interest_drop_q;
  assign face_valid     = face_valid_q;
  assign face_data      = face_data_q;
  assign face_mask      = face_mask_q;
  assign face_last      = face_last_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
